mult8x8_seq_ctrl: RTL and testbench

Sequential 8x8 unsigned multiplier with a combined control FSM and datapath. It forms the 16-bit product by accumulating four 4x4 partial products, one per clock. It drives the 3-bit stage code consumed directly by the 7-segment decoder:
- codes 0..3 show the active step;
- codes 4..7 display "E".

It sits upstream of the display decoder and downstream of the operand switches / start button logic.

---
 rtl/mult8x8_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_mult8x8_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier with a combined control FSM and datapath.
// The 16-bit product is built from four 4x4 partial products, one per clock.
// It also drives a 3-bit stage code to the 7-segment decoder: codes 0..3 show
// the active step, and code 3'b111 makes the decoder show "E".
module mult8x8_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [15:0] product,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [2:0]  seg_sel
);

  // The 8x8 = 4 x (4x4) decomposition fixes the step count.
  localparam int STEPS = 4;
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_count;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_product;
  logic        r_done;
  logic        r_err;
  logic [2:0]  r_seg_sel;

  state_t      w_state_nxt;
  logic [1:0]  w_count_nxt;
  logic        w_err_nxt;
  logic [2:0]  w_seg_nxt;
  logic        w_accept;
  logic [3:0]  w_nib_a;
  logic [3:0]  w_nib_b;
  logic [7:0]  w_pp;
  logic [15:0] w_addend;

  // A start is accepted only outside CALC. In CALC it only flags an error.
  assign w_accept = start && (r_state != CALC);

  // Select the nibble pair for the current step and place the product at its weight.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    w_nib_a  = r_a[3:0];
    w_nib_b  = r_b[3:0];
    w_addend = '0;
    case (r_count)
      2'd0: begin w_nib_a = r_a[3:0]; w_nib_b = r_b[3:0]; end
      2'd1: begin w_nib_a = r_a[7:4]; w_nib_b = r_b[3:0]; end
      2'd2: begin w_nib_a = r_a[3:0]; w_nib_b = r_b[7:4]; end
      default: begin w_nib_a = r_a[7:4]; w_nib_b = r_b[7:4]; end
    endcase
    w_pp = {4'h0, w_nib_a} * {4'h0, w_nib_b};
    case (r_count)
      2'd0:    w_addend = {8'h00, w_pp};
      2'd1,
      2'd2:    w_addend = {4'h0, w_pp, 4'h0};
      default: w_addend = {w_pp, 8'h00};
    endcase
  end

  // Compute the next state, count and err. The stage code is derived from these
  // so that seg_sel changes on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = CALC;
          w_count_nxt = 2'd0;
          w_err_nxt   = 1'b0;
        end
      end
      CALC: begin
        if (start) w_err_nxt = 1'b1;
        if (r_count == LAST_STEP) begin
          w_state_nxt = DONE;
          w_count_nxt = 2'd0;
        end else begin
          w_count_nxt = r_count + 2'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = 2'd0;
      end
    endcase

    // The error display takes priority over the step display.
    if (w_err_nxt) begin
      w_seg_nxt = 3'b111;
    end else begin
      case (w_state_nxt)
        CALC:    w_seg_nxt = {1'b0, w_count_nxt};
        DONE:    w_seg_nxt = 3'b011;
        default: w_seg_nxt = 3'b000;
      endcase
    end
  end

  // Register the FSM, the operands, the accumulator and the outputs.
  // A reset clears everything at once, including any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= 2'd0;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      r_product <= 16'h0000;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_seg_sel <= 3'b000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // in this block sees the values from before the edge.
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_err     <= w_err_nxt;
      r_seg_sel <= w_seg_nxt;
      if (w_accept) begin
        r_a       <= dataa;
        r_b       <= datab;
        r_product <= 16'h0000;
        r_done    <= 1'b0;
      end else if (r_state == CALC) begin
        // The worst case is 0xFF * 0xFF = 0xFE01, so 16 bits cannot overflow.
        r_product <= r_product + w_addend;
        if (r_count == LAST_STEP) r_done <= 1'b1;
      end
    end
  end

  assign product = r_product;
  assign done    = r_done;
  assign busy    = (r_state == CALC);
  assign err     = r_err;
  assign seg_sel = r_seg_sel;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Self-checking bench for mult8x8_seq_ctrl. Expected products are pushed to a
// scoreboard queue when a start is driven, and a monitor pops and compares them
// when done rises. Step codes, flags and running sums are checked inline.
module tb_mult8x8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product;
  logic        done;
  logic        busy;
  logic        err;
  logic [2:0]  seg_sel;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [15:0] sb_q[$];
  logic        prev_done;

  mult8x8_seq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dataa   (dataa),
    .datab   (datab),
    .product (product),
    .done    (done),
    .busy    (busy),
    .err     (err),
    .seg_sel (seg_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare the product when done rises.
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 32'(done), 32'd0);
      end else begin
        check("sb_product", 32'(product), 32'(sb_q.pop_front()));
      end
    end
    prev_done <= done;
  end

  // One full run. Start is driven for one cycle, and the step codes are checked
  // over the four CALC cycles and after the result edge.
  task automatic do_run(input logic [7:0] a, input logic [7:0] b, input string tag);
    start = 1'b1;
    dataa = a;
    datab = b;
    sb_q.push_back(16'(a) * 16'(b));
    tick();
    start = 1'b0;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    check({tag, "_done0"}, 32'(done), 32'd0);
    check({tag, "_err0"},  32'(err),  32'd0);
    check({tag, "_seg0"},  32'(seg_sel), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check({tag, "_seg"}, 32'(seg_sel), (k < 4) ? 32'(k) : 32'd3);
      check({tag, "_done"}, 32'(done), (k == 4) ? 32'd1 : 32'd0);
    end
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] run_ff [4];
    run_ff[0] = 16'h00E1;
    run_ff[1] = 16'h0EF1;
    run_ff[2] = 16'h1D01;
    run_ff[3] = 16'hFE01;

    rst_n = 1'b0;
    start = 1'b0;
    dataa = 8'h00;
    datab = 8'h00;
    #12;
    check("rst_product", 32'(product), 32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_seg",     32'(seg_sel), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_hold", 32'(busy), 32'd0);

    // Test 1: 0x12 * 0x34 gives 0x03A8.
    do_run(8'h12, 8'h34, "t1");
    check("t1_err", 32'(err), 32'd0);
    check("t1_product", 32'(product), 32'h03A8);

    // Test 2: 0xFF * 0xFF, checking the running partial sums.
    start = 1'b1;
    dataa = 8'hFF;
    datab = 8'hFF;
    sb_q.push_back(16'hFE01);
    tick();
    start = 1'b0;
    check("t2_cleared", 32'(product), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_running", 32'(product), 32'(run_ff[k]));
    end
    check("t2_done", 32'(done), 32'd1);

    // Test 3: 0x00 * 0xA5, then an immediate restart from DONE with 0x01 * 0xA5.
    do_run(8'h00, 8'hA5, "t3a");
    check("t3a_product", 32'(product), 32'h0000);
    do_run(8'h01, 8'hA5, "t3b");
    check("t3b_product", 32'(product), 32'h00A5);

    // Test 4: start pulsed in CALC at count=2 sets err. The result is unaffected.
    start = 1'b1;
    dataa = 8'h10;
    datab = 8'h10;
    sb_q.push_back(16'h0100);
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t4_seg_cnt2", 32'(seg_sel), 32'd2);
    start = 1'b1;
    dataa = 8'hFF;
    datab = 8'hFF;
    tick();
    start = 1'b0;
    check("t4_err", 32'(err), 32'd1);
    check("t4_seg_err", 32'(seg_sel), 32'h7);
    tick();
    check("t4_done", 32'(done), 32'd1);
    check("t4_product", 32'(product), 32'h0100);
    check("t4_err_sticky", 32'(err), 32'd1);
    check("t4_seg_sticky", 32'(seg_sel), 32'h7);
    tick();
    check("t4_err_hold", 32'(err), 32'd1);
    do_run(8'h0B, 8'h0D, "t4c");

    // Test 5: an asynchronous reset at count=1 aborts the run at once.
    start = 1'b1;
    dataa = 8'h55;
    datab = 8'h66;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_product", 32'(product), 32'd0);
    check("t5_done",    32'(done),    32'd0);
    check("t5_busy",    32'(busy),    32'd0);
    check("t5_seg",     32'(seg_sel), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_idle_busy", 32'(busy), 32'd0);
      check("t5_idle_seg",  32'(seg_sel), 32'd0);
    end

    // Test 6: start held high over two runs of 0x03 * 0x05.
    start = 1'b1;
    dataa = 8'h03;
    datab = 8'h05;
    sb_q.push_back(16'h000F);
    sb_q.push_back(16'h000F);
    tick();
    check("t6_err_e0", 32'(err), 32'd0);
    tick();
    check("t6_err_run1", 32'(err), 32'd1);
    check("t6_seg_run1", 32'(seg_sel), 32'h7);
    tick();
    tick();
    tick();
    check("t6_done1", 32'(done), 32'd1);
    check("t6_prod1", 32'(product), 32'h000F);
    tick();
    check("t6_done_1cyc", 32'(done), 32'd0);
    check("t6_restart_busy", 32'(busy), 32'd1);
    check("t6_err_cleared", 32'(err), 32'd0);
    tick();
    check("t6_err_run2", 32'(err), 32'd1);
    check("t6_seg_run2", 32'(seg_sel), 32'h7);
    tick();
    tick();
    start = 1'b0;
    tick();
    check("t6_done2", 32'(done), 32'd1);
    check("t6_prod2", 32'(product), 32'h000F);
    tick();
    check("t6_done_hold", 32'(done), 32'd1);
    check("t6_busy_hold", 32'(busy), 32'd0);

    tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
